// File: rtl/mult_share_sched_pkg.sv
// Shared types and helpers for the round-robin shared multiplier scheduler.
package mult_share_sched_pkg;

  // Scheduler states, fixed encodings so waveforms read the same everywhere.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_sched_dp.sv
// Shift-add unsigned multiplier datapath: one multiplier bit retired per step.
module shift_add_dp #(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   x,
  output logic [2*WIDTH-1:0] prod
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [WIDTH:0]   sum;

  // Conditional add of A into the high half; the extra bit is the carry c.
  always_comb begin
    sum = {1'b0, p_hi};
    if (p_lo[0]) begin
      sum = {1'b0, p_hi} + {1'b0, a_reg};
    end
  end

  // Load clears the accumulator and parks X in the low half; each step shifts {c, P_hi, P_lo} right.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      a_reg <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else if (load) begin
      a_reg <= a;
      p_hi  <= '0;
      p_lo  <= x;
    end else if (step) begin
      {p_hi, p_lo} <= {sum, p_lo[WIDTH-1:1]};
    end
  end

  assign prod = {p_hi, p_lo};

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler that shares one shift-add multiplier among NREQ requesters.
module mult_share_sched
  import mult_share_sched_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] x_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [2*WIDTH-1:0]    Result
);

  localparam int CW = id_width(WIDTH);

  state_t             state;
  state_t             next_state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     pick;
  logic               any_req;
  logic [CW-1:0]      step_cnt;
  logic               last_step;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   x_sel;
  logic [2*WIDTH-1:0] prod;

  // Round-robin search: first asserted request at or after ptr, wrapping to 0.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req[(int'(ptr) + k) % NREQ]) begin
        any_req = 1'b1;
        pick    = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign last_step = (step_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        load       = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (last_step) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Winner/pointer capture at grant time, step counting and the result/done registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      ptr      <= '0;
      winner   <= '0;
      step_cnt <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      Result   <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        winner <= pick;
        ptr    <= (int'(pick) == NREQ - 1) ? '0 : pick + IDW'(1);
      end
      if (state == S_LOAD) begin
        step_cnt <= '0;
      end else if (state == S_RUN) begin
        step_cnt <= step_cnt + CW'(1);
      end
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        Result  <= prod;
        done_id <= winner;
      end
    end
  end

  // One-hot grant for the single LOAD cycle.
  always_comb begin
    gnt = '0;
    if (state == S_LOAD) begin
      gnt[winner] = 1'b1;
    end
  end

  assign busy  = (state != S_IDLE);
  assign a_sel = a_in[int'(winner)*WIDTH +: WIDTH];
  assign x_sel = x_in[int'(winner)*WIDTH +: WIDTH];

  shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .Clock  (Clock),
    .Resetn (Resetn),
    .load   (load),
    .step   (step),
    .a      (a_sel),
    .x      (x_sel),
    .prod   (prod)
  );

endmodule
